// File: rtl/fb_port_arbiter_if.sv
// Requester and BRAM-side signal bundle for fb_port_arbiter.
// The arbiter takes the slave view; a requester/BRAM harness takes the master view.
interface fb_port_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
);
  // Handshake semantics: wr_valid offers one pixel per cycle with no ready path,
  // so the arbiter either queues it or drops it in that same cycle. rd_req is
  // accepted unconditionally, and rd_valid pulses exactly RD_LAT+1 cycles later,
  // in request order, with rd_data valid only while rd_valid is high.
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [DATA_W-1:0] bram_dout;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, bram_dout,
    output rd_valid, rd_data, bram_en, bram_we, bram_addr, bram_din
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_req, rd_addr, bram_dout,
    input  rd_valid, rd_data, bram_en, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: reads win, writes queue in a small FIFO, clear FSM fills the buffer.
// Optional drop statistics counter enabled by defining FB_ARB_STATS_EN.
module fb_port_arbiter #(
  parameter int                ADDR_W      = 17,
  parameter int                DATA_W      = 12,
  parameter int                DEPTH_WORDS = 76800,
  parameter int                FIFO_DEPTH  = 4,
  parameter int                RD_LAT      = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = 12'h000
) (
  input  logic                 clk,
  input  logic                 rst,
  fb_port_arbiter_if.slave     bus,
  input  logic                 clear_req,
  output logic                 clear_busy,
  output logic                 wr_overflow,
  input  logic                 ovf_clr,
  output logic [15:0]          drop_count,
  output logic                 dbg_state
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] MAX_ADDR  = ADDR_W'(DEPTH_WORDS - 1);
  localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  logic              fifo_full;
  logic              fifo_empty;
  logic              gnt_clr;
  logic              pop;
  logic              push_ok;
  logic              push;
  logic              drop;

  logic              bram_en_q;
  logic              bram_we_q;
  logic [ADDR_W-1:0] bram_addr_q;
  logic [DATA_W-1:0] bram_din_q;
  logic [RD_LAT:0]   rd_pipe;
  logic              ovf_q;

  assign fifo_full  = (count == FIFO_FULL);
  assign fifo_empty = (count == '0);

  // Grant priority: read, then clear write, then FIFO head.
  assign gnt_clr = !bus.rd_req && (state == S_CLEAR);
  assign pop     = !bus.rd_req && (state != S_CLEAR) && !fifo_empty;

  // Out-of-range addresses never enter the FIFO and are not counted as drops.
  assign push_ok = bus.wr_valid && (bus.wr_addr <= MAX_ADDR);
  assign push    = push_ok && (!fifo_full || pop);
  assign drop    = push_ok && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.wr_addr;
      fifo_data[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Address and data hold their last value on idle cycles; only en/we drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
    end else begin
      bram_en_q <= 1'b0;
      bram_we_q <= 1'b0;
      if (bus.rd_req) begin
        bram_en_q   <= 1'b1;
        bram_addr_q <= bus.rd_addr;
      end else if (gnt_clr) begin
        bram_en_q   <= 1'b1;
        bram_we_q   <= 1'b1;
        bram_addr_q <= clr_ptr;
        bram_din_q  <= CLEAR_VALUE;
      end else if (pop) begin
        bram_en_q   <= 1'b1;
        bram_we_q   <= 1'b1;
        bram_addr_q <= fifo_addr[rd_ptr];
        bram_din_q  <= fifo_data[rd_ptr];
      end
    end
  end

  // One stage for the registered BRAM command plus RD_LAT stages of BRAM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= bus.rd_req;
      for (int i = 1; i <= RD_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      clr_ptr    <= '0;
      clear_busy <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (clear_req) begin
            state      <= S_CLEAR;
            clr_ptr    <= '0;
            clear_busy <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (gnt_clr) begin
            if (clr_ptr == MAX_ADDR) begin
              state      <= S_IDLE;
              clear_busy <= 1'b0;
            end else begin
              clr_ptr <= clr_ptr + 1'b1;
            end
          end
        end
        default: begin
          state      <= S_IDLE;
          clear_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

`ifdef FB_ARB_STATS_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop) begin
      if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end else if (ovf_clr) begin
      drop_cnt_q <= '0;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

  assign wr_overflow   = ovf_q;
  assign dbg_state     = state;
  assign bus.bram_en   = bram_en_q;
  assign bus.bram_we   = bram_we_q;
  assign bus.bram_addr = bram_addr_q;
  assign bus.bram_din  = bram_din_q;
  assign bus.rd_valid  = rd_pipe[RD_LAT];
  assign bus.rd_data   = bus.bram_dout;

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= FIFO_FULL);
  a_we_has_en:   assert property (@(posedge clk) disable iff (rst) bram_we_q |-> bram_en_q);

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Randomized bench for fb_port_arbiter against a queue/shadow-memory reference model.
// Compile with FB_ARB_STATS_EN to also check the drop counter.
module tb_fb_port_arbiter;
  localparam int          ADDR_W     = 17;
  localparam int          DATA_W     = 12;
  localparam int          DEPTH      = 76800;
  localparam int          FIFO_DEPTH = 4;
  localparam int          RD_LAT     = 1;
  localparam int          MAX_ADDR   = DEPTH - 1;
  localparam logic [11:0] CLR_VAL    = 12'h000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        clear_req;
  logic        clear_busy;
  logic        wr_overflow;
  logic        ovf_clr;
  logic [15:0] drop_count;
  logic        dbg_state;

  fb_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_WORDS(DEPTH),
    .FIFO_DEPTH(FIFO_DEPTH), .RD_LAT(RD_LAT), .CLEAR_VALUE(CLR_VAL)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .wr_overflow(wr_overflow), .ovf_clr(ovf_clr),
    .drop_count(drop_count), .dbg_state(dbg_state)
  );

  // BRAM behavioural model, one cycle read latency
  logic [11:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.bram_en) begin
      if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
      else             bus.bram_dout <= mem[bus.bram_addr];
    end
  end

  // ---------------- reference model state ----------------
  typedef struct {
    logic [16:0] addr;
    logic [11:0] data;
  } wr_t;

  int          cyc = 0;
  bit          m_en, m_we, m_busy, m_ovf, clr_on;
  logic [16:0] m_addr;
  logic [11:0] m_din;
  int          m_drops, clr_ptr;
  wr_t         fq[$];
  logic [11:0] shadow [DEPTH];
  bit          known [DEPTH];

  // scoreboard: expected read data with due cycle and known flag
  logic [DATA_W-1:0] exp_q[$];
  int                exp_due_q[$];
  bit                exp_known_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic mwrite(input int a, input logic [11:0] d);
    m_en      = 1'b1;
    m_we      = 1'b1;
    m_addr    = 17'(a);
    m_din     = d;
    shadow[a] = d;
    known[a]  = 1'b1;
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    bit  was_on;
    bit  drop;
    wr_t e;
    cyc++;
    if (rst) begin
      m_en = 0; m_we = 0; m_addr = '0; m_din = '0;
      m_busy = 0; m_ovf = 0; m_drops = 0; clr_on = 0; clr_ptr = 0;
      fq.delete(); exp_q.delete(); exp_due_q.delete(); exp_known_q.delete();
    end else begin
      m_en = 0; m_we = 0;
      was_on = clr_on;
      drop = 0;
      if (bus.rd_req) begin
        m_en   = 1'b1;
        m_addr = bus.rd_addr;
        exp_q.push_back(shadow[int'(bus.rd_addr)]);
        exp_due_q.push_back(cyc + RD_LAT);
        exp_known_q.push_back(known[int'(bus.rd_addr)]);
      end else if (clr_on) begin
        mwrite(clr_ptr, CLR_VAL);
        if (clr_ptr == MAX_ADDR) clr_on = 0;
        else clr_ptr++;
      end else if (fq.size() > 0) begin
        e = fq.pop_front();
        mwrite(int'(e.addr), e.data);
      end
      if (bus.wr_valid && int'(bus.wr_addr) <= MAX_ADDR) begin
        if (fq.size() < FIFO_DEPTH) begin
          e.addr = bus.wr_addr;
          e.data = bus.wr_data;
          fq.push_back(e);
        end else begin
          drop = 1;
        end
      end
      if (!was_on && clear_req) begin
        clr_on  = 1;
        clr_ptr = 0;
      end
      if (drop) begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end else if (ovf_clr) begin
        m_ovf   = 0;
        m_drops = 0;
      end
      m_busy = clr_on;
    end
  endtask

  task automatic check_outputs();
    bit          v;
    bit          k;
    logic [11:0] d;
    int          due;
    check("bram_en", bus.bram_en, m_en);
    check("bram_we", bus.bram_we, m_we);
    check("bram_addr", bus.bram_addr, m_addr);
    check("bram_din", bus.bram_din, m_din);
    check("clear_busy", clear_busy, m_busy);
    check("dbg_state", dbg_state, m_busy);
    check("wr_overflow", wr_overflow, m_ovf);
`ifdef FB_ARB_STATS_EN
    check("drop_count", drop_count, m_drops);
`else
    check("drop_count", drop_count, 32'd0);
`endif
    v = (exp_due_q.size() > 0) && (exp_due_q[0] == cyc);
    check("rd_valid", bus.rd_valid, v);
    if (v) begin
      d   = exp_q.pop_front();
      due = exp_due_q.pop_front();
      k   = exp_known_q.pop_front();
      if (k) check("rd_data", bus.rd_data, d);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 0; bus.rd_addr = '0;
    clear_req = 0; ovf_clr = 0;
  endtask

  task automatic idle(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_read(input string tag, input int a, input logic [11:0] exp);
    idle_inputs();
    bus.rd_req  = 1;
    bus.rd_addr = 17'(a);
    cycle();
    idle_inputs();
    cycle();
    check(tag, bus.rd_data, exp);
  endtask

  task automatic rand_cycle(input int rd_pct, input int wr_pct);
    bus.rd_req  = ($urandom_range(0, 99) < rd_pct);
    bus.rd_addr = ($urandom_range(0, 7) == 0) ? 17'($urandom_range(0, MAX_ADDR))
                                              : 17'($urandom_range(0, 63));
    bus.wr_valid = ($urandom_range(0, 99) < wr_pct);
    bus.wr_addr  = ($urandom_range(0, 9) == 0) ? 17'($urandom_range(0, 131071))
                                               : 17'($urandom_range(0, 63));
    bus.wr_data  = 12'($urandom);
    ovf_clr      = ($urandom_range(0, 49) == 0);
    clear_req    = 0;
    cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_clr;
    bit done;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    rst = 1;
    idle_inputs();
    for (int i = 0; i < 3; i++) cycle();
    rst = 0;
    idle(2);

    // write only
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      bus.wr_valid = 1;
      bus.wr_addr  = 17'(i);
      bus.wr_data  = 12'h100 + 12'(i);
      cycle();
    end
    idle(4);
    for (int i = 0; i < 8; i++) check("wr_mem", mem[i], 12'h100 + 12'(i));
    check("wr_no_ovf", wr_overflow, 0);

    // read only
    do_read("rd_addr5", 5, 12'h105);
    idle(2);

    // contention: reads hold off four writes, which then drain
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      bus.rd_req   = 1;
      bus.rd_addr  = 17'(i);
      bus.wr_valid = 1;
      bus.wr_addr  = 17'(16 + i);
      bus.wr_data  = 12'($urandom);
      cycle();
    end
    idle(6);
    check("cont_no_ovf", wr_overflow, 0);

    // overflow: six writes behind eight reads
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      bus.rd_req   = 1;
      bus.rd_addr  = 17'(i);
      bus.wr_valid = (i < 6);
      bus.wr_addr  = 17'(32 + i);
      bus.wr_data  = 12'h200 + 12'(i);
      cycle();
      if (i == 5) begin
        check("ovf_flag", wr_overflow, 1);
`ifdef FB_ARB_STATS_EN
        check("ovf_drops", drop_count, 2);
`endif
      end
    end
    idle(6);
    idle_inputs();
    ovf_clr = 1;
    cycle();
    idle_inputs();
    check("ovf_cleared", wr_overflow, 0);
    check("drops_cleared", drop_count, 0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 2000; i++) rand_cycle(45, 60);
    idle(8);

    // reset one cycle after a read request
    idle_inputs();
    bus.rd_req  = 1;
    bus.rd_addr = 17'd3;
    cycle();
    idle_inputs();
    rst = 1;
    cycle();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("rst_rd_valid", bus.rd_valid, 0);
    end

    // reset in the middle of a clear
    idle_inputs();
    clear_req = 1;
    cycle();
    for (int i = 0; i < 40; i++) rand_cycle(30, 50);
    idle_inputs();
    rst = 1;
    cycle();
    rst = 0;
    check("rst_clear_busy", clear_busy, 0);
    check("rst_bram_en", bus.bram_en, 0);
    check("rst_ovf", wr_overflow, 0);
    idle(3);
    check("rst_fifo_empty", bus.bram_en, 0);

    // full clear with interleaved reads, queued writes and an ignored second request
    idle_inputs();
    clear_req = 1;
    cycle();
    n_clr = 0;
    done  = 0;
    for (int i = 0; i < 80000; i++) begin
      idle_inputs();
      if (i % 7000 == 3) begin
        bus.rd_req  = 1;
        bus.rd_addr = 17'($urandom_range(0, MAX_ADDR));
      end
      if (i >= 100 && i < 106) begin
        bus.wr_valid = 1;
        bus.wr_addr  = 17'(100 + i - 100);
        bus.wr_data  = 12'hABC;
      end
      clear_req = (i == 500);
      cycle();
      if (bus.bram_we && bus.bram_din == CLR_VAL) n_clr++;
      if (!m_busy && fq.size() == 0) begin
        done = 1;
        break;
      end
    end
    check("clear_done", done, 1);
    check("clear_writes", n_clr, DEPTH);
    idle(2);
    do_read("clr_rd_first", 0, CLR_VAL);
    do_read("clr_rd_last", MAX_ADDR, CLR_VAL);
    idle(3);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
